// File: rtl/drv_led_pkg.sv
// Shared encodings for the LED pattern driver: command modes and FSM states.
package drv_led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  typedef enum logic [2:0] {
    S_OFF,
    S_ON,
    S_BLINK_H,
    S_BLINK_L,
    S_BREATHE
  } state_t;

endpackage

// File: rtl/drv_tick.sv
// Base-tick prescaler: one-cycle o_tick every TICK_DIV cycles, the first one
// TICK_DIV cycles after i_clr.
module drv_tick #(
  parameter int TICK_DIV = 27_000
) (
  input  logic gclk,
  input  logic gresetn,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge gclk) begin
    if (!gresetn)                     r_cnt <= '0;
    else if (i_clr || r_cnt == '0)    r_cnt <= RELOAD;
    else                              r_cnt <= r_cnt - 1'b1;
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/drv_led.sv
// LED pattern driver: OFF / ON / BLINK (finite or endless) / BREATHE (PWM
// triangle ramp), commanded over a valid/ready handshake.
//
// state     | meaning
// S_OFF     | led off, idle
// S_ON      | led steadily on
// S_BLINK_H | blink on-phase
// S_BLINK_L | blink off-phase; decides repeat / finish
// S_BREATHE | PWM output, duty ramps 0..max..0 continuously
module drv_led #(
  parameter int   TICK_DIV          = 27_000,
  parameter int   BLINK_HALF_TICKS  = 250,
  parameter int   BREATH_STEP_TICKS = 4,
  parameter int   PWM_BITS          = 8,
  parameter logic LED_ON            = 1'b1
) (
  input  logic       gclk,
  input  logic       gresetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_count,
  output logic       done,
  output logic       led
);
  import drv_led_pkg::*;

  localparam int PH_MAX = (BLINK_HALF_TICKS > BREATH_STEP_TICKS) ? BLINK_HALF_TICKS : BREATH_STEP_TICKS;
  localparam int PHW    = $clog2(PH_MAX + 1);
  localparam logic [PHW-1:0]      PH_BLINK  = PHW'(BLINK_HALF_TICKS);
  localparam logic [PHW-1:0]      PH_BREATH = PHW'(BREATH_STEP_TICKS);
  localparam logic [PHW-1:0]      PH_ONE    = PHW'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_rem, w_rem_nxt;
  logic [PHW-1:0]      r_phase, w_phase_nxt;
  logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
  logic [PWM_BITS-1:0] r_pwm, w_pwm_nxt;
  logic                r_dir_up, w_dir_nxt;
  logic                r_led, r_ready, r_done;
  logic                w_led_nxt, w_ready_nxt, w_done_nxt;
  logic                w_accept, w_tick;

  assign w_accept  = cmd_valid && r_ready;
  assign cmd_ready = r_ready;
  assign done      = r_done;
  assign led       = r_led;

  drv_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .gclk    (gclk),
    .gresetn (gresetn),
    .i_clr   (w_accept),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_phase_nxt = r_phase;
    w_duty_nxt  = r_duty;
    w_dir_nxt   = r_dir_up;
    w_pwm_nxt   = r_pwm + 1'b1;
    w_done_nxt  = 1'b0;
    if (w_accept) begin
      w_pwm_nxt   = '0;
      w_duty_nxt  = '0;
      w_dir_nxt   = 1'b1;
      w_rem_nxt   = '0;
      w_phase_nxt = '0;
      case (cmd_mode)
        MODE_OFF: w_state_nxt = S_OFF;
        MODE_ON:  w_state_nxt = S_ON;
        MODE_BLINK: begin
          w_state_nxt = S_BLINK_H;
          w_rem_nxt   = cmd_count;
          w_phase_nxt = PH_BLINK;
        end
        default: begin
          w_state_nxt = S_BREATHE;
          w_phase_nxt = PH_BREATH;
        end
      endcase
    end else if (w_tick) begin
      // r_phase counts ticks down; the phase ends on the tick that finds it at 1
      case (r_state)
        S_BLINK_H: begin
          if (r_phase == PH_ONE) begin
            w_state_nxt = S_BLINK_L;
            w_phase_nxt = PH_BLINK;
          end else w_phase_nxt = r_phase - 1'b1;
        end
        S_BLINK_L: begin
          if (r_phase == PH_ONE) begin
            w_phase_nxt = PH_BLINK;
            if (r_rem == 8'd1) begin
              w_state_nxt = S_OFF;
              w_rem_nxt   = '0;
              w_phase_nxt = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_BLINK_H;
              if (r_rem != 8'd0) w_rem_nxt = r_rem - 1'b1;
            end
          end else w_phase_nxt = r_phase - 1'b1;
        end
        S_BREATHE: begin
          if (r_phase == PH_ONE) begin
            w_phase_nxt = PH_BREATH;
            if (r_dir_up) begin
              if (r_duty == DUTY_MAX) begin
                w_dir_nxt  = 1'b0;
                w_duty_nxt = r_duty - 1'b1;
              end else w_duty_nxt = r_duty + 1'b1;
            end else begin
              if (r_duty == '0) begin
                w_dir_nxt  = 1'b1;
                w_duty_nxt = r_duty + 1'b1;
              end else w_duty_nxt = r_duty - 1'b1;
            end
          end else w_phase_nxt = r_phase - 1'b1;
        end
        default: ;
      endcase
    end

    // led and ready are registered from next-state values so they follow the FSM without lag
    case (w_state_nxt)
      S_ON, S_BLINK_H: w_led_nxt = LED_ON;
      S_BREATHE:       w_led_nxt = (w_pwm_nxt < w_duty_nxt) ? LED_ON : ~LED_ON;
      default:         w_led_nxt = ~LED_ON;
    endcase
    w_ready_nxt = !(((w_state_nxt == S_BLINK_H) || (w_state_nxt == S_BLINK_L)) && (w_rem_nxt != 8'd0));
  end

  always_ff @(posedge gclk) begin
    if (!gresetn) begin
      r_state  <= S_OFF;
      r_rem    <= '0;
      r_phase  <= '0;
      r_duty   <= '0;
      r_pwm    <= '0;
      r_dir_up <= 1'b1;
      r_led    <= ~LED_ON;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rem    <= w_rem_nxt;
      r_phase  <= w_phase_nxt;
      r_duty   <= w_duty_nxt;
      r_pwm    <= w_pwm_nxt;
      r_dir_up <= w_dir_nxt;
      r_led    <= w_led_nxt;
      r_ready  <= w_ready_nxt;
      r_done   <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_drv_led.sv
// Bench for drv_led: directed and random commands checked every cycle against a
// time-since-command model of the LED pattern.
module tb_drv_led;

  localparam int TD   = 4;
  localparam int BH   = 2;
  localparam int BS   = 1;
  localparam int PB   = 3;
  localparam int HALF = BH * TD;
  localparam int DMAX = (1 << PB) - 1;

  logic       gclk = 1'b0;
  logic       gresetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_count = 8'd0;
  logic       done;
  logic       led;

  int n_chk = 0;
  int n_err = 0;

  int   m_mode = 0;
  int   m_cnt  = 0;
  int   m_t    = 0;
  bit   m_rst  = 1'b1;
  logic e_led = 1'b0, e_ready = 1'b0, e_done = 1'b0;

  drv_led #(
    .TICK_DIV(TD), .BLINK_HALF_TICKS(BH), .BREATH_STEP_TICKS(BS),
    .PWM_BITS(PB), .LED_ON(1'b1)
  ) dut (
    .gclk(gclk), .gresetn(gresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_count(cmd_count), .done(done), .led(led)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b (mode %0d t %0d)", tag, $time, got, exp, m_mode, m_t);
    end
  endtask

  function automatic int tri_duty(input int step);
    int m;
    m = step % (2 * DMAX);
    return (m <= DMAX) ? m : (2 * DMAX - m);
  endfunction

  // Expected outputs follow from the active mode and the cycles elapsed since it was accepted.
  task automatic model_edge(input logic v, input logic [1:0] m, input logic [7:0] c, input logic rn);
    if (!rn) begin
      m_rst = 1'b1; m_mode = 0; m_t = 0;
    end else begin
      if (v && e_ready) begin
        m_mode = int'(m); m_cnt = int'(c); m_t = 0;
      end else m_t++;
      m_rst = 1'b0;
    end
    e_led = 1'b0; e_ready = 1'b1; e_done = 1'b0;
    if (m_rst) e_ready = 1'b0;
    else begin
      case (m_mode)
        1: e_led = 1'b1;
        2: begin
          if (m_cnt == 0) e_led = ((m_t % (2 * HALF)) < HALF);
          else if (m_t < m_cnt * 2 * HALF) begin
            e_led = ((m_t % (2 * HALF)) < HALF);
            e_ready = 1'b0;
          end else if (m_t == m_cnt * 2 * HALF) e_done = 1'b1;
        end
        3: e_led = ((m_t % (1 << PB)) < tri_duty(m_t / (BS * TD)));
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic v, input logic [1:0] m, input logic [7:0] c, input logic rn);
    cmd_valid = v; cmd_mode = m; cmd_count = c; gresetn = rn;
    @(posedge gclk);
    model_edge(v, m, c, rn);
    #1;
    chk("led", led, e_led);
    chk("cmd_ready", cmd_ready, e_ready);
    chk("done", done, e_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'd0, 1'b1);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 8'd0, 1'b0);
    idle(3);

    step(1'b1, 2'd1, 8'd0, 1'b1); idle(5);
    step(1'b1, 2'd0, 8'd0, 1'b1); idle(3);

    // count=2 blink with an ON command pressed against the closed handshake
    step(1'b1, 2'd2, 8'd2, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 2'd1, 8'd0, 1'b1);
    idle(24);

    step(1'b1, 2'd2, 8'd0, 1'b1); idle(20);
    step(1'b1, 2'd0, 8'd0, 1'b1); idle(4);

    step(1'b1, 2'd3, 8'd0, 1'b1); idle(70);
    step(1'b1, 2'd3, 8'd0, 1'b1); idle(6);

    // BREATHE issued exactly in the done cycle of a count=1 blink
    step(1'b1, 2'd2, 8'd1, 1'b1);
    guard = 0;
    while (!e_done && guard < 40) begin
      idle(1);
      guard++;
    end
    chk("done_seen", e_done, 1'b1);
    step(1'b1, 2'd3, 8'd0, 1'b1); idle(20);
    step(1'b0, 2'd0, 8'd0, 1'b0);
    step(1'b0, 2'd0, 8'd0, 1'b0);
    idle(2);

    for (int i = 0; i < 1500; i++) begin
      logic v, rn;
      v  = ($urandom_range(0, 7) == 0);
      rn = ($urandom_range(0, 149) != 0);
      step(v, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
